// File: rtl/mem_if_pkg.sv
// Shared definitions for the L1 miss/store protocol: FSM states, ack encoding
// and line geometry, common to the L1 data cache and its backing memory.
package mem_if_pkg;

   localparam int WORD_W         = 32;
   localparam int WORDS_PER_LINE = 8;
   localparam int OFFSET_BITS    = 3;
   localparam logic [3:0] ACK_NONE = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      LD_WAIT,
      LD_BEAT,
      ST_DATA,
      ST_DONE
   } state_t;

   // States in which a falling VALID abandons the request
   function automatic logic abortable(input state_t s);
      return (s == ADDR) || (s == LD_WAIT) || (s == LD_BEAT) || (s == ST_DATA);
   endfunction

endpackage

// File: rtl/main_memory_responder_if.sv
// Request/response bus between the L1 data cache (master) and the memory
// responder (slave); split in/out data buses.
interface main_memory_responder_if;
   import mem_if_pkg::*;

   logic              VALID;
   logic              LOAD;
   logic              STORE;
   logic              ACK_ADDR;
   logic [WORD_W-1:0] DATA_IN;
   logic [3:0]        ACK_DATA_L1;
   logic              READY;
   logic              ADDR_TAKEN;
   logic [WORD_W-1:0] DATA_OUT;
   logic [3:0]        ACK_DATA_MEM;

   modport master (
      output VALID, LOAD, STORE, ACK_ADDR, DATA_IN, ACK_DATA_L1,
      input  READY, ADDR_TAKEN, DATA_OUT, ACK_DATA_MEM
   );

   modport slave (
      input  VALID, LOAD, STORE, ACK_ADDR, DATA_IN, ACK_DATA_L1,
      output READY, ADDR_TAKEN, DATA_OUT, ACK_DATA_MEM
   );

endinterface

// File: rtl/main_memory_responder_mem_array.sv
// Word-addressed storage: synchronous write, combinational read, no reset.
module mem_array
   import mem_if_pkg::*;
#(
   parameter int MEM_WORDS = 1024,
   parameter int AW        = $clog2(MEM_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/main_memory_responder.sv
// Backing-store responder below the L1 data cache: in-order 8-beat line fills
// and single-word write-through. Define MEM_WAIT_EN to add WAIT_CYCLES of access delay.
module main_memory_responder
   import mem_if_pkg::*;
#(
   parameter int MEM_WORDS      = 1024,
   parameter int WORDS_PER_LINE = mem_if_pkg::WORDS_PER_LINE,
   parameter int WAIT_CYCLES    = 4
) (
   input  logic CLK,
   input  logic RST,
   main_memory_responder_if.slave bus
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int OB = $clog2(WORDS_PER_LINE);
`ifdef MEM_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif
   localparam int WAITS = WAIT_EN ? WAIT_CYCLES : 0;
   localparam int CW    = (WAITS < 2) ? 1 : $clog2(WAITS + 1);

   state_t            state, state_n;
   logic [OB-1:0]     beat, beat_n;
   logic [CW-1:0]     wait_cnt, wait_cnt_n;
   logic [AW-1:0]     addr_q, addr_n;
   logic              ld_q, ld_n;
   logic              taken_q, taken_n;
   logic              we;
   logic              wait_done;
   logic              beat_acked;
   logic [3:0]        ack_mem;
   logic [WORD_W-1:0] rdata;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         beat     <= '0;
         wait_cnt <= '0;
         addr_q   <= '0;
         ld_q     <= 1'b0;
         taken_q  <= 1'b0;
      end else begin
         state    <= state_n;
         beat     <= beat_n;
         wait_cnt <= wait_cnt_n;
         addr_q   <= addr_n;
         ld_q     <= ld_n;
         taken_q  <= taken_n;
      end
   end

   assign wait_done  = (wait_cnt == CW'(WAITS));
   assign beat_acked = (bus.ACK_DATA_L1 == 4'(beat));

   always_comb begin
      state_n    = state;
      beat_n     = beat;
      wait_cnt_n = wait_cnt;
      addr_n     = addr_q;
      ld_n       = ld_q;
      taken_n    = 1'b0;
      we         = 1'b0;
      if (abortable(state) && !bus.VALID) begin
         state_n = IDLE;
         beat_n  = '0;
      end else begin
         unique case (state)
            IDLE: begin
               // LOAD has priority when both request bits are set
               if (bus.VALID && (bus.LOAD || bus.STORE)) begin
                  ld_n    = bus.LOAD;
                  state_n = ADDR;
               end
            end
            ADDR: begin
               if (bus.ACK_ADDR) begin
                  addr_n     = bus.DATA_IN[AW-1:0];
                  taken_n    = 1'b1;
                  wait_cnt_n = '0;
                  beat_n     = '0;
                  if (!ld_q)          state_n = ST_DATA;
                  else if (WAITS == 0) state_n = LD_BEAT;
                  else                state_n = LD_WAIT;
               end
            end
            LD_WAIT: begin
               wait_cnt_n = wait_cnt + 1'b1;
               if (wait_cnt_n == CW'(WAITS)) state_n = LD_BEAT;
            end
            LD_BEAT: begin
               if (beat_acked) begin
                  if (beat == OB'(WORDS_PER_LINE - 1)) begin
                     beat_n  = '0;
                     state_n = IDLE;
                  end else begin
                     beat_n = beat + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (!wait_done) begin
                  wait_cnt_n = wait_cnt + 1'b1;
               end else if (bus.ACK_DATA_L1 == 4'h0) begin
                  we      = 1'b1;
                  state_n = ST_DONE;
               end
            end
            ST_DONE: begin
               if (!bus.VALID) state_n = IDLE;
            end
            default: begin
               state_n = IDLE;
               beat_n  = '0;
            end
         endcase
      end
   end

   // Beats walk the line from its base; the store uses the exact word address
   mem_array #(
      .MEM_WORDS (MEM_WORDS),
      .AW        (AW)
   ) u_mem (
      .clk   (CLK),
      .we    (we),
      .waddr (addr_q),
      .wdata (bus.DATA_IN),
      .raddr ({addr_q[AW-1:OB], beat}),
      .rdata (rdata)
   );

   always_comb begin
      ack_mem = ACK_NONE;
      if (state == LD_BEAT)      ack_mem = 4'(beat);
      else if (state == ST_DONE) ack_mem = 4'h0;
   end

   assign bus.READY        = (state != IDLE);
   assign bus.ADDR_TAKEN   = taken_q;
   assign bus.DATA_OUT     = (state == LD_BEAT) ? rdata : '0;
   assign bus.ACK_DATA_MEM = ack_mem;

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: table of stores and loads, scoreboard of
// expected line beats, plus hand-written abort and reset sequences.
module tb_main_memory_responder;

`ifdef MEM_WAIT_EN
   localparam int WAITS = 4;
`else
   localparam int WAITS = 0;
`endif
   localparam int NONE = 99;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } st_vec_t;

   typedef struct {
      logic [31:0] addr;
      bit          both;
      int          hold_beat;
      int          hold_cycles;
      int          abort_after;
      int          rst_at;
   } ld_vec_t;

   typedef struct {
      logic [31:0] data;
      bit          known;
   } exp_t;

   logic CLK;
   logic RST;
   main_memory_responder_if bus();

   main_memory_responder dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_chk;
   int n_pass;
   logic [31:0] mdl [int];
   exp_t sb[$];
   st_vec_t st_tab[$];
   ld_vec_t ld_tab[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
   endtask

   task automatic clear_bus();
      bus.VALID = 1'b0; bus.LOAD = 1'b0; bus.STORE = 1'b0; bus.ACK_ADDR = 1'b0;
      bus.DATA_IN = '0; bus.ACK_DATA_L1 = 4'hF;
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
      int cnt;
      bus.VALID = 1'b1; bus.STORE = 1'b1; bus.LOAD = 1'b0;
      @(negedge CLK);
      chk("st_ready", 32'(bus.READY), 1);
      bus.ACK_ADDR = 1'b1; bus.DATA_IN = addr;
      @(negedge CLK);
      chk("st_addr_taken", 32'(bus.ADDR_TAKEN), 1);
      chk("st_ack_pre", 32'(bus.ACK_DATA_MEM), 32'hF);
      bus.ACK_ADDR = 1'b0; bus.DATA_IN = data; bus.ACK_DATA_L1 = 4'h0;
      cnt = 0;
      do begin
         @(negedge CLK);
         cnt++;
      end while (bus.ACK_DATA_MEM != 4'h0 && cnt < 50);
      chk("st_latency", 32'(cnt), 32'(WAITS + 1));
      mdl[int'(addr & 32'h3FF)] = data;
      bus.ACK_DATA_L1 = 4'hF; bus.DATA_IN = '0;
      @(negedge CLK);
      chk("st_hold_ack", 32'(bus.ACK_DATA_MEM), 0);
      chk("st_hold_ready", 32'(bus.READY), 1);
      bus.VALID = 1'b0; bus.STORE = 1'b0;
      @(negedge CLK);
      chk("st_done_ready", 32'(bus.READY), 0);
      chk("st_done_ack", 32'(bus.ACK_DATA_MEM), 32'hF);
   endtask

   task automatic do_load(input ld_vec_t v);
      int cnt;
      int base;
      exp_t e;
      base = int'(v.addr & 32'h3F8);
      for (int k = 0; k < 8; k++) begin
         e.known = mdl.exists(base + k);
         e.data  = e.known ? mdl[base + k] : 32'h0;
         sb.push_back(e);
      end
      bus.VALID = 1'b1; bus.LOAD = 1'b1; bus.STORE = v.both;
      @(negedge CLK);
      chk("ld_ready", 32'(bus.READY), 1);
      bus.ACK_ADDR = 1'b1; bus.DATA_IN = v.addr;
      @(negedge CLK);
      chk("ld_addr_taken", 32'(bus.ADDR_TAKEN), 1);
      bus.ACK_ADDR = 1'b0; bus.DATA_IN = '0;
      cnt = 0;
      while (bus.ACK_DATA_MEM == 4'hF && cnt < 50) begin
         cnt++;
         @(negedge CLK);
      end
      chk("ld_wait_cycles", 32'(cnt), 32'(WAITS));
      for (int k = 0; k < 8; k++) begin
         e = sb.pop_front();
         chk("ld_beat_idx", 32'(bus.ACK_DATA_MEM), 32'(k));
         chk("ld_ready_busy", 32'(bus.READY), 1);
         if (e.known) chk("ld_beat_data", bus.DATA_OUT, e.data);
         if (k == v.rst_at) begin
            #2 RST = 1'b1;
            #1;
            chk("rst_ready", 32'(bus.READY), 0);
            chk("rst_ack", 32'(bus.ACK_DATA_MEM), 32'hF);
            chk("rst_data", bus.DATA_OUT, 0);
            @(negedge CLK);
            clear_bus();
            RST = 1'b0;
            sb.delete();
            @(negedge CLK);
            return;
         end
         if (k == v.hold_beat) begin
            for (int c = 0; c < v.hold_cycles; c++) begin
               bus.ACK_DATA_L1 = (c % 2 == 1) ? 4'hF : 4'((k + 2) % 8);
               @(negedge CLK);
               chk("hold_idx", 32'(bus.ACK_DATA_MEM), 32'(k));
               if (e.known) chk("hold_data", bus.DATA_OUT, e.data);
            end
         end
         bus.ACK_DATA_L1 = 4'(k);
         @(negedge CLK);
         bus.ACK_DATA_L1 = 4'hF;
         if (k == v.abort_after) begin
            bus.VALID = 1'b0; bus.LOAD = 1'b0; bus.STORE = 1'b0;
            @(negedge CLK);
            chk("abort_ready", 32'(bus.READY), 0);
            chk("abort_ack", 32'(bus.ACK_DATA_MEM), 32'hF);
            sb.delete();
            return;
         end
      end
      chk("ld_done_ready", 32'(bus.READY), 0);
      chk("ld_done_ack", 32'(bus.ACK_DATA_MEM), 32'hF);
      bus.VALID = 1'b0; bus.LOAD = 1'b0; bus.STORE = 1'b0;
      @(negedge CLK);
   endtask

   function automatic ld_vec_t lv(input logic [31:0] a, input bit both, input int hb,
                                  input int hc, input int ab, input int ra);
      ld_vec_t v;
      v.addr = a; v.both = both; v.hold_beat = hb; v.hold_cycles = hc;
      v.abort_after = ab; v.rst_at = ra;
      return v;
   endfunction

   initial begin
      st_vec_t s;
      n_chk = 0; n_pass = 0;
      for (int i = 0; i < 8; i++) begin
         s.addr = 32'h40 + 32'(i); s.data = 32'hA0 + 32'(i);
         st_tab.push_back(s);
      end
      s.addr = 32'h15;  s.data = 32'hDEADBEEF; st_tab.push_back(s);
      s.addr = 32'h50;  s.data = 32'h11111111; st_tab.push_back(s);
      s.addr = 32'h3FF; s.data = 32'h12345678; st_tab.push_back(s);
      s.addr = 32'hF420; s.data = 32'hCAFE0001; st_tab.push_back(s);

      ld_tab.push_back(lv(32'h43,  0, NONE, 0, NONE, NONE));
      ld_tab.push_back(lv(32'h10,  0, NONE, 0, NONE, NONE));
      ld_tab.push_back(lv(32'h41,  0, 3,    5, NONE, NONE));
      ld_tab.push_back(lv(32'h47,  0, NONE, 0, 2,    NONE));
      ld_tab.push_back(lv(32'h45,  0, NONE, 0, NONE, NONE));
      ld_tab.push_back(lv(32'h46,  1, NONE, 0, NONE, NONE));
      ld_tab.push_back(lv(32'h50,  0, NONE, 0, NONE, NONE));
      ld_tab.push_back(lv(32'h3FF, 0, NONE, 0, NONE, NONE));
      ld_tab.push_back(lv(32'h820, 0, NONE, 0, NONE, NONE));
      ld_tab.push_back(lv(32'h44,  0, NONE, 0, NONE, 4));
      ld_tab.push_back(lv(32'h40,  0, NONE, 0, NONE, NONE));
      ld_tab.push_back(lv(32'h17,  0, 5,    2, NONE, NONE));

      clear_bus();
      RST = 1'b1;
      #1;
      chk("reset_ready", 32'(bus.READY), 0);
      chk("reset_taken", 32'(bus.ADDR_TAKEN), 0);
      chk("reset_data", bus.DATA_OUT, 0);
      chk("reset_ack", 32'(bus.ACK_DATA_MEM), 32'hF);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);

      foreach (st_tab[i]) do_store(st_tab[i].addr, st_tab[i].data);

      // VALID without LOAD or STORE is not a request
      bus.VALID = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      chk("no_op_ready", 32'(bus.READY), 0);
      bus.VALID = 1'b0;
      @(negedge CLK);

      // Store abandoned before its data beat: the word must not change
      bus.VALID = 1'b1; bus.STORE = 1'b1;
      @(negedge CLK);
      bus.ACK_ADDR = 1'b1; bus.DATA_IN = 32'h50;
      @(negedge CLK);
      chk("sabort_taken", 32'(bus.ADDR_TAKEN), 1);
      bus.ACK_ADDR = 1'b0; bus.VALID = 1'b0; bus.STORE = 1'b0;
      bus.DATA_IN = 32'h22222222; bus.ACK_DATA_L1 = 4'h0;
      @(negedge CLK);
      chk("sabort_ready", 32'(bus.READY), 0);
      chk("sabort_ack", 32'(bus.ACK_DATA_MEM), 32'hF);
      clear_bus();
      @(negedge CLK);

      foreach (ld_tab[i]) do_load(ld_tab[i]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
- Memory-side responder for the L1 data-cache miss/store protocol: VALID/READY handshake, address phase, then word-indexed acknowledged data beats.
- Serves 8-word line fills on LOAD and single-word write-through on STORE from an internal word-addressed array.
- Sits below the L1 data cache as its backing store. Uses split in/out buses in place of shared inout lines.

Parameters:
- MEM_WORDS, 1024, depth of the storage array in 32-bit words (power of two).
- WORDS_PER_LINE, 8, beats per line fill; line base = address with low log2(WORDS_PER_LINE) bits cleared.
- WAIT_CYCLES, 4, first-beat access delay; used only with MEM_WAIT_EN.

Ports:
- CLK  in  1  clock, all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- VALID  in  1  L1 request outstanding.
- LOAD  in  1  request is a line fill.
- STORE  in  1  request is a word write.
- ACK_ADDR  in  1  L1 is driving the address on DATA_IN.
- DATA_IN  in  32  address during address phase; store data during store data phase.
- ACK_DATA_L1  in  4  index of the beat L1 has consumed (store: 0 = data valid); 4'hF = none.
- READY  out  1  responder has accepted the request.
- ADDR_TAKEN  out  1  one-cycle pulse: address latched.
- DATA_OUT  out  32  load beat data.
- ACK_DATA_MEM  out  4  index of the beat on DATA_OUT (load) or store written (0); 4'hF = none.

Behaviour:
- Reset (async, RST=1): READY=0, ADDR_TAKEN=0, DATA_OUT=0, ACK_DATA_MEM=4'hF, state=IDLE, beat counter=0. Array contents are not reset.
- Word address = DATA_IN[log2(MEM_WORDS)-1:0]. Upper bits are ignored, so addresses alias modulo MEM_WORDS.
- IDLE: on VALID with LOAD or STORE, set READY=1 next cycle and go to ADDR. If LOAD and STORE are both 1, LOAD wins. VALID with neither set is ignored.
- ADDR: on ACK_ADDR=1, latch addr_q=DATA_IN, pulse ADDR_TAKEN for one cycle, then go to LD_BEAT (LOAD) or ST_DATA (STORE).
- LD_BEAT, beat k (k starts at 0):
  - Drive DATA_OUT=mem[line_base+k] and ACK_DATA_MEM=k, held stable until ACK_DATA_L1==k.
  - On that ack, present beat k+1 on the next cycle. The burst is in-order starting at beat 0, not critical-word-first.
  - After ack of beat WORDS_PER_LINE-1: READY=0, ACK_DATA_MEM=4'hF, go to IDLE.
  - Best case is 1 cycle per beat. Minimum load latency: VALID → READY 1 cycle; ACK_ADDR → beat 0 valid 1 cycle.
- ST_DATA: on ACK_DATA_L1==0, write mem[addr_q]=DATA_IN (full word, the exact address, not the line base), set ACK_DATA_MEM=0, go to ST_DONE.
- ST_DONE: hold ACK_DATA_MEM=0 and READY=1 until VALID=0, then ACK_DATA_MEM=4'hF, READY=0, go to IDLE.
- VALID falling in ADDR, LD_BEAT or ST_DATA aborts: next cycle READY=0, ACK_DATA_MEM=4'hF, IDLE, and no write is performed.
- A new request is accepted no earlier than the cycle after returning to IDLE. There are no back-to-back requests without an IDLE cycle.
- ACK_DATA_L1 values other than the current beat index are ignored, with no state change.
- RST asserted mid-burst or mid-store: outputs go to reset values immediately. A store write already committed on an earlier edge persists.

Optional Feature:
- MEM_WAIT_EN defined: state LD_WAIT is inserted between ADDR and LD_BEAT. It counts WAIT_CYCLES cycles with ACK_DATA_MEM=4'hF, then presents beat 0. Stores also spend WAIT_CYCLES in ST_DATA before honouring ACK_DATA_L1==0. Aborting on VALID fall applies during the wait.
- MEM_WAIT_EN undefined: zero wait states, with timing as in Behaviour.

Decomposition:
- Shared package mem_if_pkg holds:
  - state enum (IDLE, ADDR, LD_WAIT, LD_BEAT, ST_DATA, ST_DONE);
  - ACK_NONE=4'hF;
  - WORD_W=32;
  - WORDS_PER_LINE and OFFSET_BITS=3, shared with the L1 cache.
- One sub-module, mem_array: a synchronous-write, combinational-read MEM_WORDS×32 RAM with a single read and a single write port.

Test Plan:
- Preload mem[0x40..0x47]=0xA0..0xA7; LOAD, address 0x43 → ADDR_TAKEN pulse; beats 0..7 = 0xA0..0xA7 with ACK_DATA_MEM 0..7; READY falls after the ack of beat 7.
- STORE address 0x15, data 0xDEADBEEF, ACK_DATA_L1=0 → ACK_DATA_MEM=0 held until VALID=0; a following LOAD of 0x10 returns 0xDEADBEEF at beat 5.
- L1 withholds the ack of beat 3 for 5 cycles → DATA_OUT and ACK_DATA_MEM=3 stay stable; beat 4 appears the cycle after the ack.
- VALID dropped after beat 2 is acked → next cycle READY=0, ACK_DATA_MEM=4'hF, IDLE; a new LOAD then completes normally.
- RST pulsed during beat 4, asynchronously between edges → outputs reset immediately without waiting for CLK; earlier stored data is intact.
- With MEM_WAIT_EN and WAIT_CYCLES=4: LOAD → exactly 4 cycles of ACK_DATA_MEM=4'hF after ADDR_TAKEN before beat 0.
